// File: rtl/montacargas_shaft_emulator.sv
// Plant model of the three-floor lift shaft: integrates car position from the motor command and drives FC1..FC3.
// Optional spin-up delay on motion start is enabled with `define MONTACARGAS_EMU_INERTIA_EN.
module montacargas_shaft_emulator #(
  parameter int TICKS_PER_FLOOR = 300,
  parameter int STEP_DIV        = 13333,
  parameter int INIT_FLOOR      = 2,
  parameter int START_STEPS     = 30,
  parameter int POS_W           = 12
) (
  input  logic             clockBase_4MHz,
  input  logic             reset,
  input  logic [1:0]       driverMotor,
  output logic             FC1,
  output logic             FC2,
  output logic             FC3,
  output logic [POS_W-1:0] posicion,
  output logic             enMovimiento,
  output logic             fault
);

  localparam int POS_MAX_I = 2 * TICKS_PER_FLOOR;
  localparam logic [POS_W-1:0] POS_MAX    = POS_W'(POS_MAX_I);
  localparam logic [POS_W-1:0] POS_FLOOR2 = POS_W'(TICKS_PER_FLOOR);
  localparam logic [POS_W-1:0] POS_INIT   = POS_W'((INIT_FLOOR - 1) * TICKS_PER_FLOOR);
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  if (TICKS_PER_FLOOR < 2 || POS_MAX_I >= 2**POS_W || INIT_FLOOR < 1 || INIT_FLOOR > 3 ||
      STEP_DIV < 1 || START_STEPS < 0) begin : g_bad_param
    $error("montacargas_shaft_emulator: illegal parameter combination");
  end

  typedef enum logic [1:0] {ST_REPOSO, ST_SUBIENDO, ST_BAJANDO, ST_FAULT} state_t;

  state_t           state_q, state_d, cmd_state;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PRE_W-1:0] presc_q;
  logic             step_tick;
  logic             fc1_q, fc2_q, fc3_q, en_mov_q, fault_q;

`ifdef MONTACARGAS_EMU_INERTIA_EN
  localparam int SP_W = (START_STEPS > 0) ? $clog2(START_STEPS + 1) : 1;
  localparam logic [SP_W-1:0] SP_LOAD = SP_W'(START_STEPS);
  logic [SP_W-1:0] spin_q, spin_d;
`endif

  assign step_tick = (presc_q == PRE_LAST);

  always_comb begin
    cmd_state = ST_REPOSO;
    case (driverMotor)
      2'b01:   cmd_state = ST_SUBIENDO;
      2'b10:   cmd_state = ST_BAJANDO;
      2'b11:   cmd_state = ST_FAULT;
      default: cmd_state = ST_REPOSO;
    endcase
  end

  // A command change takes priority over a step landing in the same cycle.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
`ifdef MONTACARGAS_EMU_INERTIA_EN
    spin_d  = spin_q;
`endif
    if (state_q != ST_FAULT) begin
      if (cmd_state != state_q) begin
        state_d = cmd_state;
`ifdef MONTACARGAS_EMU_INERTIA_EN
        spin_d  = SP_LOAD;
`endif
      end else if (step_tick && state_q != ST_REPOSO) begin
`ifdef MONTACARGAS_EMU_INERTIA_EN
        if (spin_q != '0) begin
          spin_d = spin_q - SP_W'(1);
        end else
`endif
        begin
          if (state_q == ST_SUBIENDO) begin
            if (pos_q == POS_MAX) state_d = ST_FAULT;
            else                  pos_d   = pos_q + POS_W'(1);
          end else begin
            if (pos_q == '0) state_d = ST_FAULT;
            else             pos_d   = pos_q - POS_W'(1);
          end
        end
      end
    end
  end

  // Limit switches decode the current position register, so they trail it by one cycle.
  always_ff @(posedge clockBase_4MHz or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_REPOSO;
      pos_q    <= POS_INIT;
      presc_q  <= '0;
      fc1_q    <= (POS_INIT == '0);
      fc2_q    <= (POS_INIT == POS_FLOOR2);
      fc3_q    <= (POS_INIT == POS_MAX);
      en_mov_q <= 1'b0;
      fault_q  <= 1'b0;
`ifdef MONTACARGAS_EMU_INERTIA_EN
      spin_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      presc_q  <= step_tick ? '0 : presc_q + PRE_W'(1);
      fc1_q    <= (pos_q == '0);
      fc2_q    <= (pos_q == POS_FLOOR2);
      fc3_q    <= (pos_q == POS_MAX);
      en_mov_q <= (state_d == ST_SUBIENDO) || (state_d == ST_BAJANDO);
      fault_q  <= (state_d == ST_FAULT);
`ifdef MONTACARGAS_EMU_INERTIA_EN
      spin_q   <= spin_d;
`endif
    end
  end

  assign FC1          = fc1_q;
  assign FC2          = fc2_q;
  assign FC3          = fc3_q;
  assign posicion     = pos_q;
  assign enMovimiento = en_mov_q;
  assign fault        = fault_q;

endmodule
